// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//
// Contents:
//   DATA_WIDTH      default datapath width of the CPU (8 bits)
//   addsub_state_t  control states of the digit-serial engine
//   OP_ADD, OP_SUB  encodings of the op_sub input
package digit_serial_addsub_pkg;

   localparam int DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } addsub_state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/digit_serial_addsub_adder.sv
// Combinational DIGIT-bit ripple adder made of 1-bit full-adder cells.
// This is the per-cycle arithmetic slice of the digit-serial engine.
//
// Ports:
//   a, b    in   DIGIT-bit addend digits
//   cin     in   carry into bit 0
//   s       out  DIGIT-bit sum digit
//   cout    out  carry out of the top bit
//   c_top   out  carry into the top bit (feeds the signed-overflow flag)
module digit_ripple_adder #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_top
);

   logic [DIGIT:0] carry;

   // Ripple the carry through one full-adder cell per bit, bit 0 first.
   always_comb begin
      carry    = '0;
      s        = '0;
      carry[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout  = carry[DIGIT];
   assign c_top = carry[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands
// DIGIT bits per clock, least-significant digit first, with a
// start/ready/done handshake and registered result and flags.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        request, sampled only while ready is high
//   op_sub       0 = add, 1 = subtract (captured with start)
//   a, b, cin    operands and carry/borrow-in (captured with start)
//   ready        engine can accept a start this cycle (IDLE or DONE)
//   busy         engine is stepping through digits (RUN)
//   done         one-cycle pulse, result and flags valid from this cycle
//   sum          result, held until the next accepted start
//   cout         carry-out (add) or not-borrow (subtract)
//   ovf          two's-complement overflow
//   zero         result is zero
module digit_serial_addsub
   import digit_serial_addsub_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Reject digit sizes that do not tile the operand exactly.
   if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
      $error("digit_serial_addsub: DIGIT must divide WIDTH and lie in 1..WIDTH");
   end

   addsub_state_t    state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic             accept;
   logic             last_digit;
   logic [IW-1:0]    lsb;
   logic [DIGIT-1:0] dig_a, dig_b, dig_s;
   logic             dig_cout, dig_ctop;

   assign last_digit = (cnt_q == CW'(NDIG - 1));
   assign lsb        = IW'(int'(cnt_q) * DIGIT);
   assign dig_a      = a_q[lsb +: DIGIT];
   assign dig_b      = b_q[lsb +: DIGIT];
   assign accept     = ready & start;

   digit_ripple_adder #(
      .DIGIT (DIGIT)
   ) u_digit_adder (
      .a     (dig_a),
      .b     (dig_b),
      .cin   (c_q),
      .s     (dig_s),
      .cout  (dig_cout),
      .c_top (dig_ctop)
   );

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: DONE lasts exactly one cycle and may chain straight into RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_digit) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state alone.
   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      unique case (state_q)
         IDLE:    ready = 1'b1;
         RUN:     busy  = 1'b1;
         DONE: begin
            ready = 1'b1;
            done  = 1'b1;
         end
         default: ready = 1'b0;
      endcase
   end

   // Datapath next values. Subtraction is folded into capture by inverting B
   // and the incoming borrow, so the digit slice only ever adds. Flags are
   // computed on the final digit so they stay stable through the next RUN.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      c_d    = c_q;
      sum_d  = sum_q;
      cnt_d  = cnt_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
      if (accept) begin
         a_d   = a;
         b_d   = op_sub ? ~b : b;
         c_d   = cin ^ op_sub;
         sum_d = '0;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         sum_d[lsb +: DIGIT] = dig_s;
         c_d                 = dig_cout;
         if (last_digit) begin
            cnt_d  = '0;
            cout_d = dig_cout;
            ovf_d  = dig_ctop ^ dig_cout;
            zero_d = (sum_d == '0);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= 1'b0;
         sum_q  <= '0;
         cnt_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         c_q    <= c_d;
         sum_q  <= sum_d;
         cnt_q  <= cnt_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench for digit_serial_addsub. Four instances cover
// DIGIT = 1, 2, 4 and 8 on an 8-bit datapath; instance k uses DIGIT = 1<<k.
module tb_digit_serial_addsub;
   import digit_serial_addsub_pkg::*;

   typedef struct {
      string      name;
      logic       op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_sum;
      logic       exp_cout;
      logic       exp_ovf;
      logic       exp_zero;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] start_v;
   logic       op_sub;
   logic [7:0] a_in, b_in;
   logic       cin;
   logic [3:0] ready_v, busy_v, done_v, cout_v, ovf_v, zero_v;
   logic [7:0] sum_v [4];

   int n_tests;
   int n_fail;

   vec_t vec [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op_sub(op_sub), .a(a_in), .b(b_in),
      .cin(cin), .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
      .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));
   digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op_sub(op_sub), .a(a_in), .b(b_in),
      .cin(cin), .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
      .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));
   digit_serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op_sub(op_sub), .a(a_in), .b(b_in),
      .cin(cin), .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
      .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));
   digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .op_sub(op_sub), .a(a_in), .b(b_in),
      .cin(cin), .ready(ready_v[3]), .busy(busy_v[3]), .done(done_v[3]), .sum(sum_v[3]),
      .cout(cout_v[3]), .ovf(ovf_v[3]), .zero(zero_v[3]));

   function automatic int digitOf(input int k);
      return 1 << k;
   endfunction

   function automatic int ndigOf(input int k);
      return 8 / digitOf(k);
   endfunction

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic void refModel(input logic op, input logic [7:0] av, input logic [7:0] bv,
                                    input logic ci, output logic [7:0] s, output logic co,
                                    output logic ov, output logic z);
      int r, sr;
      if (op == OP_ADD) begin
         r  = int'(av) + int'(bv) + int'(ci);
         sr = int'($signed(av)) + int'($signed(bv)) + int'(ci);
         co = (r > 255);
      end else begin
         r  = int'(av) - int'(bv) - int'(ci);
         sr = int'($signed(av)) - int'($signed(bv)) - int'(ci);
         co = (r >= 0);
      end
      s  = r[7:0];
      ov = (sr > 127) || (sr < -128);
      z  = (s == 8'h00);
   endfunction

   task automatic checkOutput(input string name, input int k, input int got, input int expv);
      n_tests++;
      if (got != expv) begin
         n_fail++;
         $display("[TB] FAIL %s digit=%0d got=%0h expected=%0h", name, digitOf(k), got, expv);
      end
   endtask

   // Present operands and hold start across one rising edge.
   task automatic applyStimulus(input int k, input logic op, input logic [7:0] av,
                                input logic [7:0] bv, input logic ci);
      op_sub     = op;
      a_in       = av;
      b_in       = bv;
      cin        = ci;
      start_v[k] = 1'b1;
      @(posedge clk);
      #1;
      start_v[k] = 1'b0;
   endtask

   // Counts edges after the accept edge until done is seen.
   task automatic waitDone(input int k, output int edges, output int busy_cnt);
      edges    = 0;
      busy_cnt = 0;
      while (!done_v[k] && edges < 40) begin
         if (busy_v[k]) busy_cnt++;
         @(posedge clk);
         #1;
         edges++;
      end
      if (!done_v[k]) checkOutput("doneTimeout", k, 0, 1);
   endtask

   task automatic checkResult(input string name, input int k, input logic [7:0] s,
                              input logic co, input logic ov, input logic z);
      checkOutput({name, ".sum"}, k, int'(sum_v[k]), int'(s));
      checkOutput({name, ".cout"}, k, int'(cout_v[k]), int'(co));
      checkOutput({name, ".ovf"}, k, int'(ovf_v[k]), int'(ov));
      checkOutput({name, ".zero"}, k, int'(zero_v[k]), int'(z));
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int edges, busy_cnt, seen;
      logic [7:0] es;
      logic eco, eov, ez;
      logic rop, rci;
      logic [7:0] ra, rb;

      n_tests = 0;
      n_fail  = 0;

      vec[0] = '{"addWrap",   OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
      vec[1] = '{"subOvf",    OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
      vec[2] = '{"subBorrow", OP_SUB, 8'h05, 8'h07, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0};
      vec[3] = '{"addOvf",    OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      vec[4] = '{"addCin",    OP_ADD, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
      vec[5] = '{"subZero",   OP_SUB, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
      vec[6] = '{"addNegOvf", OP_ADD, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
      vec[7] = '{"subNegB",   OP_SUB, 8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};

      rst_n   = 1'b0;
      start_v = '0;
      op_sub  = OP_ADD;
      a_in    = '0;
      b_in    = '0;
      cin     = 1'b0;

      #12;
      for (int k = 0; k < 4; k++) begin
         checkOutput("rst.ready", k, int'(ready_v[k]), 1);
         checkOutput("rst.busy", k, int'(busy_v[k]), 0);
         checkOutput("rst.done", k, int'(done_v[k]), 0);
         checkResult("rst", k, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 4; k++) begin
         // Directed table, each entry chained back-to-back from the previous DONE.
         for (int v = 0; v < 8; v++) begin
            applyStimulus(k, vec[v].op, vec[v].a, vec[v].b, vec[v].cin);
            waitDone(k, edges, busy_cnt);
            checkOutput({vec[v].name, ".latency"}, k, edges, ndigOf(k));
            checkOutput({vec[v].name, ".busyCycles"}, k, busy_cnt, ndigOf(k));
            checkResult(vec[v].name, k, vec[v].exp_sum, vec[v].exp_cout,
                        vec[v].exp_ovf, vec[v].exp_zero);
         end

         // Back-to-back: start in the DONE cycle is accepted immediately.
         checkOutput("b2b.readyInDone", k, int'(ready_v[k]), 1);
         applyStimulus(k, OP_SUB, 8'h80, 8'h01, 1'b0);
         checkOutput("b2b.busyAfter", k, int'(busy_v[k]), 1);
         checkOutput("b2b.doneAfter", k, int'(done_v[k]), 0);
         waitDone(k, edges, busy_cnt);
         checkOutput("b2b.latency", k, edges, ndigOf(k));
         checkResult("b2b", k, 8'h7F, 1'b1, 1'b1, 1'b0);

         // Result and flags hold once DONE has passed.
         @(posedge clk);
         #1;
         checkOutput("hold.done", k, int'(done_v[k]), 0);
         checkOutput("hold.ready", k, int'(ready_v[k]), 1);
         checkResult("hold", k, 8'h7F, 1'b1, 1'b1, 1'b0);

         // start pulsed during RUN with different operands must be ignored.
         if (ndigOf(k) > 1) begin
            applyStimulus(k, OP_ADD, 8'hFF, 8'h01, 1'b0);
            applyStimulus(k, OP_SUB, 8'h55, 8'h11, 1'b1);
            waitDone(k, edges, busy_cnt);
            checkOutput("runStart.latency", k, edges, ndigOf(k) - 1);
            checkResult("runStart", k, 8'h00, 1'b1, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            checkOutput("runStart.noRestart", k, int'(busy_v[k]), 0);
         end

         // Reset in the second RUN cycle aborts with no done.
         if (ndigOf(k) > 2) begin
            applyStimulus(k, OP_SUB, 8'h05, 8'h07, 1'b1);
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            checkOutput("midRst.ready", k, int'(ready_v[k]), 1);
            checkOutput("midRst.busy", k, int'(busy_v[k]), 0);
            checkOutput("midRst.done", k, int'(done_v[k]), 0);
            checkResult("midRst", k, 8'h00, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
            seen  = 0;
            for (int j = 0; j < ndigOf(k) + 3; j++) begin
               @(posedge clk);
               #1;
               if (done_v[k]) seen = 1;
            end
            checkOutput("midRst.noDone", k, seen, 0);
            checkOutput("midRst.sumKept", k, int'(sum_v[k]), 0);
         end

         // Randomised operations against the arithmetic reference.
         for (int i = 0; i < 1000; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rci = 1'($urandom_range(0, 1));
            refModel(rop, ra, rb, rci, es, eco, eov, ez);
            applyStimulus(k, rop, ra, rb, rci);
            waitDone(k, edges, busy_cnt);
            checkOutput("rand.latency", k, edges, ndigOf(k));
            checkResult("rand", k, es, eco, eov, ez);
         end
         @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
